// File: rtl/dsc_pkg.sv
// Shared constants and helpers for the DSC stochastic-to-binary receiver.
package dsc_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   // Default geometry and the widths derived from it
   localparam int unsigned DEF_NUM_INPUTS = 4;
   localparam int unsigned DEF_NUM_BITS   = 10;
   localparam int unsigned DEF_OUT_W      = DEF_NUM_INPUTS * DEF_NUM_BITS;
   localparam int unsigned DEF_K_W        = $clog2(DEF_NUM_INPUTS + 1);

   // Widest frame mask the helper can describe
   localparam int unsigned MASK_W = 64;

   // Low k*num_bits bits set; callers truncate to their counter width.
   function automatic logic [MASK_W-1:0] frame_mask(input int unsigned k,
                                                    input int unsigned num_bits);
      int unsigned n;
      n = k * num_bits;
      if (n >= MASK_W) return '1;
      return (MASK_W'(1) << n) - MASK_W'(1);
   endfunction

endpackage

// File: rtl/dsc_stoch2bin_rx_frame_ctr.sv
// Frame bit counter: counts accepted bits and flags the last bit of a frame.
module dsc_frame_ctr #(
   parameter int unsigned W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] mask,
   output logic         last
);

   logic [W-1:0] cnt;

   // Counter: reset/clear to zero, advance on each accepted bit
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (inc)   cnt <= cnt + W'(1);
   end

   // Last bit when every bit inside the frame mask is already set
   assign last = inc && ((cnt & mask) == mask);

endmodule

// File: rtl/dsc_stoch2bin_rx.sv
// Framed unary-stream decoder: counts ones over 2^(k*NUM_BITS) bits and
// returns the count through a valid/ready handshake.
module dsc_stoch2bin_rx
   import dsc_pkg::*;
#(
   parameter  int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
   parameter  int unsigned NUM_BITS   = DEF_NUM_BITS,
   localparam int unsigned OUT_W      = NUM_INPUTS * NUM_BITS,
   localparam int unsigned K_W        = $clog2(NUM_INPUTS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [K_W-1:0]   n_active,
   input  logic             sn_in,
   input  logic             sn_valid,
   output logic             sn_ready,
   output logic [OUT_W-1:0] z,
   output logic             z_sat,
   output logic             z_valid,
   input  logic             z_ready,
   output logic             ov,
   output logic             busy
);

   logic [1:0]       state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [OUT_W:0]   ones_q, ones_d, ones_sum;
   logic [OUT_W-1:0] z_d, mask;
   logic             z_sat_d, z_valid_d, ov_d;
   logic             accept, frame_last, ctr_clr;

   assign sn_ready = (state_q == ST_COUNT) && en;
   assign busy     = (state_q != ST_IDLE);
   assign accept   = sn_valid && sn_ready;
   assign ones_sum = ones_q + (OUT_W+1)'(sn_in);
   assign mask     = OUT_W'(frame_mask(32'(k_q), NUM_BITS));

   dsc_frame_ctr #(.W(OUT_W)) u_frame_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (ctr_clr),
      .inc  (accept),
      .mask (mask),
      .last (frame_last)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      ones_d    = ones_q;
      z_d       = z;
      z_sat_d   = z_sat;
      z_valid_d = z_valid;
      ov_d      = 1'b0;
      ctr_clr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_COUNT;
               if (n_active == '0)                  k_d = K_W'(1);
               else if (n_active > K_W'(NUM_INPUTS)) k_d = K_W'(NUM_INPUTS);
               else                                  k_d = n_active;
            end
         end
         ST_COUNT: begin
            if (accept) begin
               ones_d = ones_sum;
               if (frame_last) begin
                  state_d   = ST_HOLD;
                  z_d       = ones_sum[OUT_W] ? '1 : ones_sum[OUT_W-1:0];
                  z_sat_d   = ones_sum[OUT_W];
                  z_valid_d = 1'b1;
                  ov_d      = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (z_valid && z_ready) begin
               state_d   = ST_IDLE;
               z_valid_d = 1'b0;
               ones_d    = '0;
               ctr_clr   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= K_W'(1);
         ones_q  <= '0;
         z       <= '0;
         z_sat   <= 1'b0;
         z_valid <= 1'b0;
         ov      <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ones_q  <= ones_d;
         z       <= z_d;
         z_sat   <= z_sat_d;
         z_valid <= z_valid_d;
         ov      <= ov_d;
      end
   end

endmodule

// File: tb/tb_dsc_stoch2bin_rx.sv
// Self-checking bench for dsc_stoch2bin_rx: small instance against a cycle
// model, plus a default-width-style instance fed a full 4-operand DSC product.
module tb_dsc_stoch2bin_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small instance: NUM_INPUTS=2, NUM_BITS=2 -> OUT_W=4, K_W=2
   logic       rst, en, sn_in, sn_valid, z_ready;
   logic [1:0] n_active;
   logic       sn_ready, z_sat, z_valid, ov, busy;
   logic [3:0] z;

   dsc_stoch2bin_rx #(.NUM_INPUTS(2), .NUM_BITS(2)) u_dut (
      .clk(clk), .rst(rst), .en(en), .n_active(n_active), .sn_in(sn_in),
      .sn_valid(sn_valid), .sn_ready(sn_ready), .z(z), .z_sat(z_sat),
      .z_valid(z_valid), .z_ready(z_ready), .ov(ov), .busy(busy)
   );

   // Product instance: NUM_INPUTS=4, NUM_BITS=4 -> OUT_W=16, K_W=3
   logic        b_rst, b_en, b_sn_in, b_sn_valid, b_z_ready;
   logic [2:0]  b_n_active;
   logic        b_sn_ready, b_z_sat, b_z_valid, b_ov, b_busy;
   logic [15:0] b_z;

   dsc_stoch2bin_rx #(.NUM_INPUTS(4), .NUM_BITS(4)) u_big (
      .clk(clk), .rst(b_rst), .en(b_en), .n_active(b_n_active), .sn_in(b_sn_in),
      .sn_valid(b_sn_valid), .sn_ready(b_sn_ready), .z(b_z), .z_sat(b_z_sat),
      .z_valid(b_z_valid), .z_ready(b_z_ready), .ov(b_ov), .busy(b_busy)
   );

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the small instance: frame bookkeeping in plain integers
   int m_busy = 0, m_hold = 0, m_k = 1, m_cnt = 0, m_ones = 0;
   int m_z = 0, m_zs = 0, m_zv = 0, m_ov = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_hold = 0; m_k = 1; m_cnt = 0; m_ones = 0;
         m_z = 0; m_zs = 0; m_zv = 0; m_ov = 0;
      end else begin
         m_ov = 0;
         if (m_busy == 0) begin
            if (en) begin
               m_busy = 1;
               m_k = (n_active == 2'd0) ? 1 : ((int'(n_active) > 2) ? 2 : int'(n_active));
            end
         end else if (m_hold == 0) begin
            if (en && sn_valid) begin
               m_cnt  = m_cnt + 1;
               m_ones = m_ones + 32'(sn_in);
               if (m_cnt == (1 << (m_k * 2))) begin
                  m_z  = (m_ones > 15) ? 15 : m_ones;
                  m_zs = (m_ones > 15) ? 1 : 0;
                  m_zv = 1; m_ov = 1; m_hold = 1;
               end
            end
         end else if (z_ready) begin
            m_zv = 0; m_hold = 0; m_busy = 0; m_cnt = 0; m_ones = 0;
         end
      end
   end

   // Per-cycle comparison of every small-instance output against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("sn_ready", 32'(sn_ready), 32'((m_busy != 0) && (m_hold == 0) && en));
         chk("busy",     32'(busy),     32'(m_busy));
         chk("z",        32'(z),        32'(m_z));
         chk("z_sat",    32'(z_sat),    32'(m_zs));
         chk("z_valid",  32'(z_valid),  32'(m_zv));
         chk("ov",       32'(ov),       32'(m_ov));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_frame(input int k);
      en = 1'b1; n_active = 2'(k);
      tick();
   endtask

   task automatic feed(input logic [15:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         sn_in = pat[i]; sn_valid = 1'b1;
         tick();
      end
      sn_valid = 1'b0; sn_in = 1'b0; en = 1'b0;
   endtask

   task automatic release_z();
      z_ready = 1'b1;
      tick();
      z_ready = 1'b0;
   endtask

   // Product stream: four clock-divided unary streams of value 15, ANDed
   logic [15:0] b_z_got;
   logic        b_zs_got, b_zv_got, b_ov_got;
   bit          big_done = 1'b0;

   initial begin
      b_rst = 1'b1; b_en = 1'b0; b_n_active = 3'd0; b_sn_in = 1'b0;
      b_sn_valid = 1'b0; b_z_ready = 1'b0;
      tick(); tick();
      b_rst = 1'b0; b_en = 1'b1; b_n_active = 3'd4;
      tick();
      for (int t = 0; t < 65536; t++) begin
         b_sn_in = ((t & 15) < 15) && (((t >> 4) & 15) < 15) &&
                   (((t >> 8) & 15) < 15) && (((t >> 12) & 15) < 15);
         b_sn_valid = 1'b1;
         tick();
      end
      b_sn_valid = 1'b0; b_en = 1'b0;
      b_z_got = b_z; b_zs_got = b_z_sat; b_zv_got = b_z_valid; b_ov_got = b_ov;
      big_done = 1'b1;
   end

   initial begin
      int tally, acc, cyc, k, kc, len, pc;
      logic [15:0] pat;

      rst = 1'b1; en = 1'b1; n_active = 2'd2; sn_in = 1'b0; sn_valid = 1'b0; z_ready = 1'b0;
      tick(); tick();
      chk_on = 1'b1;
      // Reset state (en high during reset must not start a frame)
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_zv", 32'(z_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(sn_ready), 32'd0);
      rst = 1'b0; en = 1'b0;
      tick();

      // 1: k=2, 16 bits, 6 ones
      start_frame(2);
      feed(16'h8721, 16);
      chk("t1_ov", 32'(ov), 32'd1);
      chk("t1_z", 32'(z), 32'd6);
      chk("t1_zsat", 32'(z_sat), 32'd0);
      chk("t1_zv", 32'(z_valid), 32'd1);
      tick();
      chk("t1_ov_pulse", 32'(ov), 32'd0);
      release_z();

      // 2: k=1 all ones, then n_active=0 clamps to 1
      start_frame(1);
      feed(16'h000F, 4);
      chk("t2_z_k1", 32'(z), 32'd4);
      release_z();
      start_frame(0);
      feed(16'h000F, 4);
      chk("t2_z_k0", 32'(z), 32'd4);
      chk("t2_zv_k0", 32'(z_valid), 32'd1);
      release_z();

      // 3: k=2, 16 ones saturates
      start_frame(2);
      feed(16'hFFFF, 16);
      chk("t3_z", 32'(z), 32'd15);
      chk("t3_zsat", 32'(z_sat), 32'd1);

      // 4: hold with z_ready low, en and sn_valid asserted
      en = 1'b1; sn_valid = 1'b1; sn_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_zv", 32'(z_valid), 32'd1);
         chk("t4_hold_z", 32'(z), 32'd15);
         chk("t4_hold_ready", 32'(sn_ready), 32'd0);
      end
      en = 1'b0; sn_valid = 1'b0; sn_in = 1'b0;
      release_z();
      chk("t4_zv_drop", 32'(z_valid), 32'd0);
      chk("t4_busy_drop", 32'(busy), 32'd0);
      chk("t4_z_kept", 32'(z), 32'd15);

      // 5: random sn_valid gaps and en low for 3 cycles mid-frame
      start_frame(2);
      tally = 0; acc = 0; cyc = 0;
      while (acc < 16 && cyc < 300) begin
         en = !(cyc >= 4 && cyc < 7);
         sn_valid = ($urandom_range(2) != 0);
         sn_in = $urandom_range(1) != 0;
         if (en && sn_valid) begin acc++; tally += 32'(sn_in); end
         tick();
         cyc++;
      end
      en = 1'b0; sn_valid = 1'b0; sn_in = 1'b0;
      chk("t5_budget", 32'(acc), 32'd16);
      chk("t5_z", 32'(z), 32'((tally > 15) ? 15 : tally));
      chk("t5_ov", 32'(ov), 32'd1);
      release_z();

      // 6: reset mid-frame, then a clean 3-ones frame
      start_frame(2);
      feed(16'h007F, 7);
      rst = 1'b1; en = 1'b1;
      tick();
      chk("t6_rst_z", 32'(z), 32'd0);
      chk("t6_rst_zv", 32'(z_valid), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_ready", 32'(sn_ready), 32'd0);
      rst = 1'b0; en = 1'b0;
      tick();
      start_frame(2);
      feed(16'h0124, 16);
      chk("t6_z", 32'(z), 32'd3);
      release_z();

      // Random frames with random k and random consumer delay
      for (int f = 0; f < 8; f++) begin
         k = int'($urandom_range(3));
         kc = (k == 0) ? 1 : ((k > 2) ? 2 : k);
         len = 1 << (2 * kc);
         pat = 16'($urandom);
         pc = 0;
         for (int i = 0; i < len; i++) pc += 32'(pat[i]);
         start_frame(k);
         feed(pat, len);
         chk("rnd_z", 32'(z), 32'((pc > 15) ? 15 : pc));
         chk("rnd_zsat", 32'(z_sat), 32'(pc > 15));
         repeat ($urandom_range(3)) tick();
         release_z();
      end

      // 7: 4-operand product 15^4 over a 2^16-bit frame
      cyc = 0;
      while (!big_done && cyc < 70000) begin tick(); cyc++; end
      chk("t7_done", 32'(big_done), 32'd1);
      chk("t7_z", 32'(b_z_got), 32'd50625);
      chk("t7_zsat", 32'(b_zs_got), 32'd0);
      chk("t7_zv", 32'(b_zv_got), 32'd1);
      chk("t7_ov", 32'(b_ov_got), 32'd1);

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
